// File: rtl/conv_pkg.sv
// Shared types and default geometry for the streaming convolution window controller
// and the line-buffer top that instantiates it.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DefImgW = 11;
    localparam int unsigned DefImgH = 8;
    localparam int unsigned DefK    = 3;

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter with synchronous clear, advance enable and a
// flag marking the last pixel of the frame.
module raster_counter #(
    parameter int unsigned Width  = 11,
    parameter int unsigned Height = 8,
    parameter int unsigned CW     = $clog2(Width),
    parameter int unsigned RW     = $clog2(Height)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_end, row_end;

    always_comb begin
        col_end = (col_q == CW'(Width - 1));
        row_end = (row_q == RW'(Height - 1));
        col_d   = col_q;
        row_d   = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (col_end) begin
                col_d = '0;
                // Wrapping past the final row returns to the frame origin.
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = col_end & row_end;

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences the KxK line-buffer window: accepts raster pixels, drives the shared shift
// enable and presents each complete neighbourhood with a valid/ready handshake.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = DefImgW,
    parameter int unsigned IMG_H = DefImgH,
    parameter int unsigned K     = DefK,
    parameter int unsigned CW    = $clog2(IMG_W),
    parameter int unsigned RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done
);

    state_e        state_q, state_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [CW-1:0] cnt_col;
    logic [RW-1:0] cnt_row;
    logic          cnt_last, cnt_clr, win_hit;

    raster_counter #(
        .Width  (IMG_W),
        .Height (IMG_H),
        .CW     (CW),
        .RW     (RW)
    ) u_raster_counter (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .en   (shift_en),
        .col  (cnt_col),
        .row  (cnt_row),
        .last (cnt_last)
    );

    // A held window blocks shifting so the line-buffer contents stay stable under it.
    assign in_ready = (state_q == StRun) && (!win_valid_q || win_ready);
    assign shift_en = in_valid & in_ready;
    assign win_hit  = shift_en && (cnt_row >= RW'(K - 1)) && (cnt_col >= CW'(K - 1));

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_clr = 1'b1;
                end
            end
            StRun: begin
                if (shift_en && cnt_last) state_d = StDrain;
            end
            StDrain: begin
                if (win_valid_q && win_ready) state_d = StDone;
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        // A qualifying shift in the consume cycle replaces the window back-to-back.
        if (win_hit) begin
            win_valid_d = 1'b1;
            win_row_d   = cnt_row;
            win_col_d   = cnt_col;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: a 4x3 instance for directed frames and an 11x8 instance
// for randomized valid/ready, both checked against a frame-level window model.
module tb_conv_window_ctrl;

    logic clk = 1'b0;
    logic rstn_s, rstn_b, sel;
    logic start, in_valid, win_ready;

    logic       ir_s, se_s, wv_s, busy_s, fd_s;
    logic [1:0] row_s, col_s;
    logic       ir_b, se_b, wv_b, busy_b, fd_b;
    logic [2:0] row_b;
    logic [3:0] col_b;

    logic        o_ir, o_se, o_wv, o_busy, o_fd;
    logic [31:0] o_row, o_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_ctrl #(
        .IMG_W (4),
        .IMG_H (3),
        .K     (3)
    ) u_small (
        .clk        (clk),
        .rstn       (rstn_s),
        .start      (start & ~sel),
        .in_valid   (in_valid & ~sel),
        .in_ready   (ir_s),
        .shift_en   (se_s),
        .win_valid  (wv_s),
        .win_ready  (win_ready & ~sel),
        .win_row    (row_s),
        .win_col    (col_s),
        .busy       (busy_s),
        .frame_done (fd_s)
    );

    conv_window_ctrl #(
        .IMG_W (11),
        .IMG_H (8),
        .K     (3)
    ) u_big (
        .clk        (clk),
        .rstn       (rstn_b),
        .start      (start & sel),
        .in_valid   (in_valid & sel),
        .in_ready   (ir_b),
        .shift_en   (se_b),
        .win_valid  (wv_b),
        .win_ready  (win_ready & sel),
        .win_row    (row_b),
        .win_col    (col_b),
        .busy       (busy_b),
        .frame_done (fd_b)
    );

    always_comb begin
        o_ir   = sel ? ir_b : ir_s;
        o_se   = sel ? se_b : se_s;
        o_wv   = sel ? wv_b : wv_s;
        o_busy = sel ? busy_b : busy_s;
        o_fd   = sel ? fd_b : fd_s;
        o_row  = sel ? {29'd0, row_b} : {30'd0, row_s};
        o_col  = sel ? {28'd0, col_b} : {30'd0, col_s};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, o_ir}, 0);
        chk({tag, "_shift_en"}, {31'd0, o_se}, 0);
        chk({tag, "_win_valid"}, {31'd0, o_wv}, 0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 0);
        chk({tag, "_frame_done"}, {31'd0, o_fd}, 0);
        chk({tag, "_win_row"}, o_row, 0);
        chk({tag, "_win_col"}, o_col, 0);
    endtask

    // Model: pixel n is (n / w, n % w); it completes a window when both coordinates
    // reach k-1. A presented window stays until consumed; frame_done follows the last one.
    task automatic run_frame(input int w, input int h, input int k, input bit tog,
                             input int stall, input bit restart, input int pre,
                             input int abort_at, input bit rnd);
        int n = 0, hs = 0, shs = 0, ohs = 0, fdo = 0, cyc = 0;
        int mr = 0, mc = 0, stall_left = stall;
        int tot_win = (w - k + 1) * (h - k + 1);
        bit mwv = 0, fd_due = 0, done = 0;
        bit v, wr, ir_e, sh_e, hs_now;

        for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
            #1;
            chk("pre_start_in_ready", {31'd0, o_ir}, 0);
            chk("pre_start_shift_en", {31'd0, o_se}, 0);
        end

        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, o_ir}, 0);
        chk("idle_busy", {31'd0, o_busy}, 0);

        while (!done) begin
            @(negedge clk);
            start = restart && (cyc == 3 || cyc == 8);
            if (abort_at >= 0 && n == abort_at) begin
                rstn_s = 1'b0;
                #1;
                chk_reset_outputs("async_reset");
                @(negedge clk);
                rstn_s = 1'b1;
                start = 1'b0;
                in_valid = 1'b0;
                return;
            end
            v = rnd ? ($urandom_range(0, 3) != 0) : (tog ? (cyc % 2 == 0) : 1'b1);
            if (stall_left > 0 && mwv) begin
                wr = 1'b0;
                stall_left--;
            end else begin
                wr = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            in_valid = v; win_ready = wr;
            #1;
            ir_e = (n < w * h) && (!mwv || wr);
            sh_e = v && ir_e;
            chk("in_ready", {31'd0, o_ir}, {31'd0, ir_e});
            chk("shift_en", {31'd0, o_se}, {31'd0, sh_e});
            chk("win_valid", {31'd0, o_wv}, {31'd0, mwv});
            if (mwv) begin
                chk("win_row", o_row, mr);
                chk("win_col", o_col, mc);
            end
            chk("frame_done", {31'd0, o_fd}, {31'd0, fd_due});
            chk("busy_in_frame", {31'd0, o_busy}, 1);
            if (o_se) shs++;
            if (o_wv && wr) ohs++;
            if (o_fd) fdo++;

            hs_now = mwv && wr;
            if (hs_now) hs++;
            if (fd_due) done = 1'b1;
            fd_due = hs_now && (hs == tot_win);
            if (sh_e && (n / w >= k - 1) && (n % w >= k - 1)) begin
                mwv = 1'b1; mr = n / w; mc = n % w;
            end else if (hs_now) begin
                mwv = 1'b0;
            end
            if (sh_e) n++;
            cyc++;
            if (!done && cyc > 2000) begin
                chk("timeout_frame_done_count", fdo, 1);
                done = 1'b1;
            end
        end

        // With start low, held in_valid must not begin another frame.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
            #1;
            chk("post_busy", {31'd0, o_busy}, 0);
            chk("post_frame_done", {31'd0, o_fd}, 0);
            chk("post_shift_en", {31'd0, o_se}, 0);
        end
        chk("shift_total", shs, w * h);
        chk("window_total", ohs, tot_win);
        chk("frame_done_count", fdo, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
        rstn_s = 1'b0; rstn_b = 1'b0;
        #12;
        chk_reset_outputs("reset_small");
        sel = 1'b1;
        #1;
        chk_reset_outputs("reset_big");
        sel = 1'b0;
        @(negedge clk);
        rstn_s = 1'b1; rstn_b = 1'b1;

        run_frame(4, 3, 3, 1'b0, 0, 1'b0, 0, -1, 1'b0);
        run_frame(4, 3, 3, 1'b0, 5, 1'b0, 0, -1, 1'b0);
        run_frame(4, 3, 3, 1'b1, 0, 1'b0, 0, -1, 1'b0);
        run_frame(4, 3, 3, 1'b0, 0, 1'b1, 3, -1, 1'b0);
        run_frame(4, 3, 3, 1'b0, 0, 1'b0, 0, 8, 1'b0);
        run_frame(4, 3, 3, 1'b0, 0, 1'b0, 0, -1, 1'b0);

        @(negedge clk);
        sel = 1'b1;
        run_frame(11, 8, 3, 1'b0, 0, 1'b0, 0, -1, 1'b1);
        run_frame(11, 8, 3, 1'b0, 3, 1'b0, 2, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequences a K-row line-buffer/window built from shift_reg2_FIFO instances for streaming 2-D convolution.
- Accepts a raster-order pixel stream with a valid/ready handshake and counts column and row.
- Drives the shared shift enable to the line buffers.
- Flags when the KxK window holds a complete neighbourhood, with backpressure from the downstream MAC stage and a per-frame done pulse.

Parameters:
- IMG_W, 11, image width in pixels (equals line-buffer length N)
- IMG_H, 8, image height in rows
- K, 3, kernel size (window is K x K), 2 <= K <= min(IMG_W, IMG_H)
- CW, $clog2(IMG_W), column counter width
- RW, $clog2(IMG_H), row counter width

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller accepts a pixel this cycle
- shift_en  out  1  enable to every line-buffer shift register; equals in_valid & in_ready
- win_valid  out  1  window contents are a complete KxK neighbourhood
- win_ready  in  1  downstream consumes the window
- win_row  out  RW  row of the newest pixel in the presented window
- win_col  out  CW  column of the newest pixel in the presented window
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse after the last window is consumed

Behaviour:
- Interface: one clock clk; reset rstn is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - col = 0, row = 0
  - in_ready, shift_en, win_valid, frame_done, busy = 0
  - win_row = 0, win_col = 0
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready = 0.
  - start = 1 moves to RUN and clears col/row to 0.
- RUN:
  - in_ready = !win_valid | win_ready. A held window blocks new shifts, so line-buffer contents stay stable while win_valid is high.
  - Each accepted pixel (shift_en = 1) is tagged (row, col). col increments; at col = IMG_W-1 it wraps to 0 and row increments.
  - In the same accepted cycle, if row >= K-1 and col >= K-1, then next cycle: win_valid = 1, win_row = row, win_col = col.
  - Latency: window valid 1 cycle after the shift that completes it, aligned with the registered shift_reg2_FIFO outputs.
- win_valid handshake:
  - Stays high until win_ready = 1.
  - The cycle of consumption: if a new qualifying pixel is accepted in the same cycle, win_valid stays 1 with updated row/col (back-to-back throughput of 1 window/cycle). Otherwise win_valid falls.
- Last pixel:
  - Accepting the pixel at (IMG_H-1, IMG_W-1) moves to DRAIN.
  - row/col wrap to 0 and in_ready = 0 from then on.
- DRAIN: wait until the final window handshake (win_valid & win_ready), then go to DONE.
- DONE:
  - frame_done = 1 for exactly one cycle, then go to IDLE.
  - busy = 0 in the IDLE cycle that follows.
- Window counts: rows with row < K-1 and columns with col < K-1 produce no window (no edge padding). Windows per frame = (IMG_W-K+1)*(IMG_H-K+1).
- start while busy is ignored. in_valid while not in RUN is not accepted (in_ready = 0).
- win_ready while win_valid = 0 has no effect.
- Asynchronous reset mid-frame returns to IDLE with all outputs at reset values. The line buffers are reset by the same rstn.
- Counters never exceed IMG_W-1 / IMG_H-1; wrap comparisons use full-width equality.

Decomposition:
- Package conv_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE)
  - default IMG_W, IMG_H, K localparams shared with the line-buffer top
- One sub-module is natural: raster_counter (col/row counter with enable, clear and last-pixel flag), reused by the output-write side of the convolution pipeline.

Test Plan (IMG_W=4, IMG_H=3, K=3 unless noted):
1. Reset, start, in_valid held high, win_ready held high -> 12 shift_en pulses. win_valid high for 2 cycles, (row,col) = (2,2) then (2,3), first 1 cycle after pixel 10. frame_done pulses once, then busy = 0.
2. Same stream, win_ready low for 5 cycles at the first window -> in_ready = 0 and shift_en = 0 during the stall. win_row/win_col held at (2,2). Stream resumes on win_ready = 1 with no pixel lost; 12 total shifts.
3. in_valid toggling 1-0-1 -> counters advance only on accepted cycles. Window coordinates match scenario 1.
4. start pulsed while busy, plus in_valid before start -> no extra frame; in_ready = 0 before start; shift_en count still 12.
5. rstn asserted low after pixel 7 -> all outputs 0 immediately (asynchronous). A new start then reproduces scenario 1 exactly.
6. IMG_W=11, IMG_H=8, K=3 random valid/ready -> exactly 54 window handshakes. Scoreboard checks each window against a reference model of the 3x3 neighbourhood.
